// File: rtl/maze_controller.sv
// maze_controller
// Moore FSM sequencing the maze-game datapath: initialises position and
// timers, samples the decoded arrow key, probes the obstacle memory at the
// target cell, then moves, blocks, respawns, freezes or declares a win.
//
// Optional feature macro: MAZE_ICE_FREEZE_EN
//   defined   : ice cells move the player, draw it frozen and block input
//               until unfrozen_i.
//   undefined : obs_ice_i is ignored (ice is open floor); FREEZE/FROZEN
//               do not exist.
//
// Ports
//   clk_i, resetn_i        clock, synchronous active-low reset
//   move_i[2:0]            decoded key: 0 none, 1 left, 2 right, 3 up, 4 down
//   obs_wall/lava/ice_i    obstacle class of the probed cell
//   unfrozen_i             freeze period elapsed
//   timer_done_i           step period elapsed
//   win_i                  player is on the goal cell
//   en_/s_xpos_o, ypos_o   position enables, selects (0 init, 1 +1, 2 -1)
//   en_/s_key_o            key register enable, select (1 capture, 0 clear)
//   en_obs_o, s_obs_o      probe register enable, probe offset (direction)
//   s_color_o              0 trail, 1 player, 2 frozen, 3 win
//   plot_o                 single-cycle VGA write strobe
//   en_/s_timer_o          step/freeze timer enable, select (1 count, 0 clear)
//   en_/s_clockt_o         game clock enable, select (1 count, 0 clear)
//   game_won_o             high while in WIN
//
// States
//   RESET     | all outputs low, waiting for resetn_i
//   INIT      | load start position, clear key, timer and game clock
//   DRAW      | plot player colour, clear timer
//   HOLD      | rate-limit: count timer until timer_done_i
//   IDLE      | capture key; latch direction on a nonzero key
//   PROBE     | load probe register at target cell, consume key
//   READ      | wait MEM_LAT cycles for obstacle memory
//   DECIDE    | wall > lava > ice > open
//   ERASE     | plot trail at the old cell
//   STEP      | move one cell along dir
//   FREEZE    | plot frozen colour, clear timer   (macro only)
//   FROZEN    | count timer, discard keys         (macro only)
//   WIN_PLOT  | plot win colour once
//   WIN_HOLD  | hold game_won until reset
module maze_controller #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic [2:0] move_i,
  input  logic       obs_wall_i,
  input  logic       obs_lava_i,
  input  logic       obs_ice_i,
  input  logic       unfrozen_i,
  input  logic       timer_done_i,
  input  logic       win_i,
  output logic       en_xpos_o,
  output logic       en_ypos_o,
  output logic [1:0] s_xpos_o,
  output logic [1:0] s_ypos_o,
  output logic       en_key_o,
  output logic       s_key_o,
  output logic       en_obs_o,
  output logic [2:0] s_obs_o,
  output logic [1:0] s_color_o,
  output logic       plot_o,
  output logic       en_timer_o,
  output logic       s_timer_o,
  output logic       en_clockt_o,
  output logic       s_clockt_o,
  output logic       game_won_o
);

  typedef enum logic [3:0] {
    ST_RESET,
    ST_INIT,
    ST_DRAW,
    ST_HOLD,
    ST_IDLE,
    ST_PROBE,
    ST_READ,
    ST_DECIDE,
    ST_ERASE,
    ST_STEP,
`ifdef MAZE_ICE_FREEZE_EN
    ST_FREEZE,
    ST_FROZEN,
`endif
    ST_WIN_PLOT,
    ST_WIN_HOLD
  } state_e;

  // READ counts down from MEM_LAT-1 to 0, giving MEM_LAT cycles in READ.
  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic [1:0] wait_q, wait_d;
  logic       respawn_q, respawn_d;
`ifdef MAZE_ICE_FREEZE_EN
  logic       freeze_q, freeze_d;
`else
  logic       unused_ice_inputs;
  assign unused_ice_inputs = obs_ice_i | unfrozen_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= ST_RESET;
      dir_q     <= 3'd0;
      wait_q    <= 2'd0;
      respawn_q <= 1'b0;
`ifdef MAZE_ICE_FREEZE_EN
      freeze_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      wait_q    <= wait_d;
      respawn_q <= respawn_d;
`ifdef MAZE_ICE_FREEZE_EN
      freeze_q  <= freeze_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    wait_d    = wait_q;
    respawn_d = respawn_q;
`ifdef MAZE_ICE_FREEZE_EN
    freeze_d  = freeze_q;
`endif
    case (state_q)
      ST_RESET: begin
        respawn_d = 1'b0;
`ifdef MAZE_ICE_FREEZE_EN
        freeze_d  = 1'b0;
`endif
        state_d   = ST_INIT;
      end
      ST_INIT:  state_d = ST_DRAW;
      ST_DRAW:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (timer_done_i) state_d = win_i ? ST_WIN_PLOT : ST_IDLE;
      end
      ST_IDLE: begin
        respawn_d = 1'b0;
`ifdef MAZE_ICE_FREEZE_EN
        freeze_d  = 1'b0;
`endif
        if (move_i != 3'd0) begin
          dir_d   = move_i;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        wait_d  = LAT_LOAD;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (wait_q == 2'd0) state_d = ST_DECIDE;
        else                wait_d  = wait_q - 2'd1;
      end
      ST_DECIDE: begin
        if (obs_wall_i) begin
          state_d = ST_IDLE;
        end else if (obs_lava_i) begin
          respawn_d = 1'b1;
          state_d   = ST_ERASE;
`ifdef MAZE_ICE_FREEZE_EN
        end else if (obs_ice_i) begin
          freeze_d = 1'b1;
          state_d  = ST_ERASE;
`endif
        end else begin
          state_d = ST_ERASE;
        end
      end
      ST_ERASE: state_d = respawn_q ? ST_INIT : ST_STEP;
`ifdef MAZE_ICE_FREEZE_EN
      ST_STEP:   state_d = freeze_q ? ST_FREEZE : ST_DRAW;
      ST_FREEZE: state_d = ST_FROZEN;
      ST_FROZEN: begin
        if (unfrozen_i) state_d = ST_DRAW;
      end
`else
      ST_STEP:   state_d = ST_DRAW;
`endif
      ST_WIN_PLOT: state_d = ST_WIN_HOLD;
      ST_WIN_HOLD: state_d = ST_WIN_HOLD;
      default:     state_d = ST_RESET;
    endcase
  end

  always_comb begin
    en_xpos_o   = 1'b0;
    en_ypos_o   = 1'b0;
    s_xpos_o    = 2'd0;
    s_ypos_o    = 2'd0;
    en_key_o    = 1'b0;
    s_key_o     = 1'b0;
    en_obs_o    = 1'b0;
    s_obs_o     = 3'd0;
    s_color_o   = 2'd0;
    plot_o      = 1'b0;
    en_timer_o  = 1'b0;
    s_timer_o   = 1'b0;
    en_clockt_o = 1'b0;
    s_clockt_o  = 1'b0;
    game_won_o  = 1'b0;
    case (state_q)
      ST_INIT: begin
        en_xpos_o   = 1'b1;
        en_ypos_o   = 1'b1;
        en_key_o    = 1'b1;
        en_timer_o  = 1'b1;
        en_clockt_o = 1'b1;
      end
      ST_DRAW: begin
        plot_o     = 1'b1;
        s_color_o  = 2'd1;
        en_timer_o = 1'b1;
      end
      ST_HOLD: begin
        en_timer_o  = 1'b1;
        s_timer_o   = 1'b1;
        en_clockt_o = 1'b1;
        s_clockt_o  = 1'b1;
      end
      ST_IDLE: begin
        en_key_o    = 1'b1;
        s_key_o     = 1'b1;
        en_clockt_o = 1'b1;
        s_clockt_o  = 1'b1;
      end
      ST_PROBE: begin
        en_obs_o = 1'b1;
        s_obs_o  = dir_q;
        en_key_o = 1'b1;
      end
      ST_ERASE: begin
        plot_o    = 1'b1;
        s_color_o = 2'd0;
      end
      ST_STEP: begin
        case (dir_q)
          3'd1: begin en_xpos_o = 1'b1; s_xpos_o = 2'd2; end
          3'd2: begin en_xpos_o = 1'b1; s_xpos_o = 2'd1; end
          3'd3: begin en_ypos_o = 1'b1; s_ypos_o = 2'd2; end
          3'd4: begin en_ypos_o = 1'b1; s_ypos_o = 2'd1; end
          default: ;
        endcase
      end
`ifdef MAZE_ICE_FREEZE_EN
      ST_FREEZE: begin
        plot_o     = 1'b1;
        s_color_o  = 2'd2;
        en_timer_o = 1'b1;
      end
      ST_FROZEN: begin
        en_timer_o = 1'b1;
        s_timer_o  = 1'b1;
        en_key_o   = 1'b1;
      end
`endif
      ST_WIN_PLOT: begin
        plot_o     = 1'b1;
        s_color_o  = 2'd3;
        game_won_o = 1'b1;
      end
      ST_WIN_HOLD: game_won_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/maze_controller.md
# maze_controller

Moore FSM that sequences the maze-game `datapath`: initialises position and timers, samples arrow keys, probes the obstacle memory at the target cell, and then moves, blocks, respawns, freezes or declares a win. It drives every enable/select of `datapath` and the `plot` strobe to the VGA adapter, and consumes the datapath flags. Sits between the PS/2 key path and `datapath` in the top level.

## Interface
- `MEM_LAT`, 1: obstacle-memory read latency in cycles, counted from the end of the probe state; legal values 1..3.
- `clk`  in  1  system clock (50 MHz).
- `resetn`  in  1  synchronous, active-low reset.
- `move`  in  3  decoded key from the datapath: 0 none, 1 left, 2 right, 3 up, 4 down.
- `obs_wall`, `obs_lava`, `obs_ice`  in  1 each  classification of the obstacle-memory pixel at `obs_x`/`obs_y`.
- `unfrozen`, `timer_done`, `win`  in  1 each  datapath flags.
- `en_xpos`, `en_ypos`  out  1 each  position register enables.
- `s_xpos`, `s_ypos`  out  2 each  position selects: 0 init, 1 +1, 2 −1.
- `en_key`, `s_key`  out  1 each  key-register enable and select: 1 capture, 0 clear.
- `en_obs`  out  1  probe-register enable.
- `s_obs`  out  3  probe offset; equals the latched direction code.
- `s_color`  out  2  colour select: 0 trail, 1 player, 2 frozen, 3 win.
- `plot`  out  1  one-cycle VGA write strobe at `xpos`/`ypos`.
- `en_timer`, `s_timer`  out  1 each  step/freeze timer enable and select: 1 count, 0 clear.
- `en_clockt`, `s_clockt`  out  1 each  game-clock enable and select: 1 count, 0 clear.
- `game_won`  out  1  high while the controller is in WIN.

## Operation
- All outputs are decoded only from the state register and a 3-bit `dir` register. Any output not listed for a state is 0.
- RESET: every output is 0; `dir` = 0. Leaves to INIT on the first edge with `resetn` = 1.
- INIT: `en_xpos`/`en_ypos` = 1 with select 0; `en_key` = 1, `s_key` = 0; `en_timer` = 1, `s_timer` = 0; `en_clockt` = 1, `s_clockt` = 0. Goes to DRAW.
- DRAW: `plot` = 1, `s_color` = 1; `en_timer` = 1, `s_timer` = 0. Goes to HOLD.
- HOLD: `en_timer` = `s_timer` = 1; `en_clockt` = `s_clockt` = 1. On `timer_done`, goes to WIN if `win` is high, otherwise to IDLE. This rate-limits moves to one per 2.5 M cycles.
- IDLE: `en_key` = `s_key` = 1; clock counting. When `move` is nonzero, latches `dir` ← `move` and goes to PROBE.
- PROBE: `en_obs` = 1, `s_obs` = `dir`; `en_key` = 1, `s_key` = 0 to consume the key. Goes to READ.
- READ: holds for `MEM_LAT` cycles via a 2-bit wait counter, then goes to DECIDE.
- DECIDE: priority is wall > lava > ice > open.
  - Wall → IDLE, with no plot.
  - Lava → ERASE with a respawn flag set.
  - Ice (macro only) → ERASE with a freeze flag set.
  - Open → ERASE.
- ERASE: `plot` = 1, `s_color` = 0 (trail at the old cell).
  - Respawn flag → INIT. The game clock is cleared there as well.
  - Otherwise → STEP.
- STEP: one cycle, driven by `dir`:
  - `dir` 1: `en_xpos` = 1, `s_xpos` = 2.
  - `dir` 2: `en_xpos` = 1, `s_xpos` = 1.
  - `dir` 3: `en_ypos` = 1, `s_ypos` = 2.
  - `dir` 4: `en_ypos` = 1, `s_ypos` = 1.
  - Next state: FREEZE if the freeze flag is set, otherwise DRAW.
- FREEZE: `plot` = 1, `s_color` = 2; timer cleared. Goes to FROZEN.
- FROZEN: timer counting, key cleared every cycle. On `unfrozen`, goes to DRAW.
- WIN: `plot` = 1, `s_color` = 3 on entry cycle only, then a held sub-state with `game_won` = 1. `en_clockt` = 0 freezes `t`. Only `resetn` leaves WIN.
- Respawn and freeze flags clear in IDLE and RESET.

## Timing
- Open move, measured from the IDLE cycle that sees `move` ≠ 0: PROBE +1, READ +2…+(1+`MEM_LAT`), DECIDE, ERASE plot, STEP, DRAW plot.
  - ERASE `plot` occurs 3+`MEM_LAT` cycles after that IDLE cycle.
  - DRAW `plot` occurs 2 cycles after ERASE.
- A wall returns to IDLE 3+`MEM_LAT` cycles after the key; the position is unchanged and no `plot` is issued.
- `plot` is always a single-cycle pulse. Two plots are never adjacent except ERASE→INIT→DRAW, which has exactly one gap cycle.
- Reset mid-operation: the edge that samples `resetn` = 0 puts the FSM in RESET, with all outputs 0 in the following cycle. An in-flight STEP is abandoned; the position is re-initialised in INIT.
- Keys pressed outside IDLE are discarded: the key register is cleared in PROBE and FROZEN and not captured elsewhere.

## Configuration
- `MAZE_ICE_FREEZE_EN` defined: ice cells move the player, draw it blue, and block input until `unfrozen` (50 M cycles after FREEZE).
- `MAZE_ICE_FREEZE_EN` undefined: `obs_ice` is ignored; ice behaves as open floor. The FREEZE and FROZEN states are not synthesised and `s_color` never equals 2.

## Test plan
- Reset: hold `resetn` = 0 for 3 cycles, then release → all outputs 0 while low; INIT asserts `en_xpos`/`en_ypos` with select 0, then DRAW `plot` with `s_color` = 1.
- Open move right, `MEM_LAT` = 1: from IDLE drive `move` = 2 with all obstacle flags low → `s_obs` = 2 in PROBE; ERASE plot (`s_color` 0) 4 cycles later; STEP `en_xpos` = 1, `s_xpos` = 1; DRAW plot 2 cycles after ERASE.
- Wall: `move` = 3, `obs_wall` = 1 → back in IDLE after 4 cycles; no `plot`; no `en_xpos`/`en_ypos`.
- Lava: `move` = 1, `obs_lava` = 1 (also set `obs_ice` = 1 to check priority) → ERASE then INIT (select 0, clock cleared), then DRAW; no STEP.
- Ice with the macro defined: `move` = 4, `obs_ice` = 1 → STEP with `s_ypos` = 1, FREEZE plot `s_color` = 2; `move` ignored until `unfrozen` pulses, then DRAW `s_color` = 1.
- Win: `win` = 1 when `timer_done` fires in HOLD → one `plot` with `s_color` = 3; `game_won` stays 1 and `en_clockt` stays 0 until `resetn` = 0.
